// File: rtl/kuznechik_round_ctrl.sv
// rtl/kuznechik_round_ctrl.sv - Kuznechik round sequencer around external S, L and key units
// Walks nine LSX rounds and the final key XOR, with a watchdog guarding the shared L unit.
module kuznechik_round_ctrl #(
  parameter int WDOG_MAX = 63
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] round_key,
  output logic [3:0]   key_idx,
  output logic [127:0] s_in,
  input  logic [127:0] s_out,
  output logic         l_enable,
  output logic [127:0] l_input_word,
  input  logic [127:0] l_output_word,
  input  logic         l_finish,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext,
  output logic         error
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    XS   = 3'd1,
    LRUN = 3'd2,
    LGAP = 3'd3,
    FIN  = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [5:0] WDOG_LAST = 6'(WDOG_MAX - 1);
  localparam logic [3:0] LAST_RND  = 4'd9;

  state_t       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] data_q, data_d;
  logic [127:0] ct_q, ct_d;
  logic [5:0]   wdog_q, wdog_d;
  logic         done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= 4'd1;
      data_q  <= '0;
      ct_q    <= '0;
      wdog_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      data_q  <= data_d;
      ct_q    <= ct_d;
      wdog_q  <= wdog_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    data_d   = data_q;
    ct_d     = ct_q;
    wdog_d   = wdog_q;
    done_d   = 1'b0;
    key_idx  = 4'd0;
    l_enable = 1'b0;
    busy     = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          data_d  = plaintext;
          rnd_d   = 4'd1;
          state_d = XS;
        end
      end
      XS: begin
        key_idx = rnd_q - 4'd1;
        data_d  = s_out;
        wdog_d  = '0;
        state_d = LRUN;
      end
      LRUN: begin
        key_idx  = rnd_q - 4'd1;
        l_enable = 1'b1;
        // A finish in the last allowed cycle still wins over the timeout.
        if (l_finish) begin
          data_d  = l_output_word;
          state_d = LGAP;
        end else begin
          wdog_d = wdog_q + 6'd1;
          if (wdog_q == WDOG_LAST) begin
            state_d = ERR;
          end
        end
      end
      LGAP: begin
        key_idx = rnd_q - 4'd1;
        if (rnd_q == LAST_RND) begin
          state_d = FIN;
        end else begin
          rnd_d   = rnd_q + 4'd1;
          state_d = XS;
        end
      end
      FIN: begin
        key_idx = 4'd9;
        ct_d    = data_q ^ round_key;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        busy = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign s_in         = data_q ^ round_key;
  assign l_input_word = data_q;
  assign ciphertext   = ct_q;
  assign done         = done_q;
  assign error        = (state_q == ERR);

endmodule

// File: tb/tb_kuznechik_round_ctrl.sv
// tb/tb_kuznechik_round_ctrl.sv - self-checking bench for kuznechik_round_ctrl
// Models the S box, L unit and key store; a scoreboard checks every done pulse.
`timescale 1ns/1ps
module tb_kuznechik_round_ctrl;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] round_key;
  logic [3:0]   key_idx;
  logic [127:0] s_in;
  logic [127:0] s_out;
  logic         l_enable;
  logic [127:0] l_input_word;
  logic [127:0] l_output_word;
  logic         l_finish;
  logic         busy;
  logic         done;
  logic [127:0] ciphertext;
  logic         error;

  kuznechik_round_ctrl #(.WDOG_MAX(63)) dut (
    .clk(clk), .rst(rst), .start(start), .plaintext(plaintext),
    .round_key(round_key), .key_idx(key_idx), .s_in(s_in), .s_out(s_out),
    .l_enable(l_enable), .l_input_word(l_input_word), .l_output_word(l_output_word),
    .l_finish(l_finish), .busy(busy), .done(done), .ciphertext(ciphertext), .error(error)
  );

  localparam logic [255:0] GOST_KEY = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
  localparam logic [127:0] GOST_PT  = 128'h1122334455667700ffeeddccbbaa9988;
  localparam logic [127:0] GOST_CT  = 128'h7f679d90bebc24305a468d42b9d4edcd;

  logic [7:0] pi_t [0:255] = '{
    252, 238, 221, 17, 207, 110, 49, 22, 251, 196, 250, 218, 35, 197, 4, 77,
    233, 119, 240, 219, 147, 46, 153, 186, 23, 54, 241, 187, 20, 205, 95, 193,
    249, 24, 101, 90, 226, 92, 239, 33, 129, 28, 60, 66, 139, 1, 142, 79,
    5, 132, 2, 174, 227, 106, 143, 160, 6, 11, 237, 152, 127, 212, 211, 31,
    235, 52, 44, 81, 234, 200, 72, 171, 242, 42, 104, 162, 253, 58, 206, 204,
    181, 112, 14, 86, 8, 12, 118, 18, 191, 114, 19, 71, 156, 183, 93, 135,
    21, 161, 150, 41, 16, 123, 154, 199, 243, 145, 120, 111, 157, 158, 178, 177,
    50, 117, 25, 61, 255, 53, 138, 126, 109, 84, 198, 128, 195, 189, 13, 87,
    223, 245, 36, 169, 62, 168, 67, 201, 215, 121, 214, 246, 124, 34, 185, 3,
    224, 15, 236, 222, 122, 148, 176, 188, 220, 232, 40, 80, 78, 51, 10, 74,
    167, 151, 96, 115, 30, 0, 98, 68, 26, 184, 56, 130, 100, 159, 38, 65,
    173, 69, 70, 146, 39, 94, 85, 47, 140, 163, 165, 125, 105, 213, 149, 59,
    7, 88, 179, 64, 134, 172, 29, 247, 48, 55, 107, 228, 136, 217, 231, 137,
    225, 27, 131, 73, 76, 63, 248, 254, 141, 83, 170, 144, 202, 216, 133, 97,
    32, 113, 103, 164, 45, 43, 9, 91, 203, 155, 37, 208, 190, 229, 108, 82,
    89, 166, 116, 210, 230, 244, 180, 192, 209, 102, 175, 194, 57, 75, 99, 182
  };
  logic [7:0] lc_t [0:15] = '{148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148, 1};
  logic [127:0] rk [1:10];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'hC3) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] sbx(input logic [127:0] a);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = pi_t[a[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] lin(input logic [127:0] a);
    logic [127:0] v;
    logic [7:0] x;
    v = a;
    for (int r = 0; r < 16; r++) begin
      x = 8'h00;
      for (int j = 0; j < 16; j++) x = x ^ gmul(v[8*(15-j) +: 8], lc_t[j]);
      v = {x, v[127:8]};
    end
    return v;
  endfunction

  task automatic key_schedule(input logic [255:0] key);
    logic [127:0] a1, a0, t, c;
    a1 = key[255:128];
    a0 = key[127:0];
    rk[1] = a1;
    rk[2] = a0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 1; j <= 8; j++) begin
        c  = lin({120'h0, 8'(8*i + j)});
        t  = lin(sbx(a1 ^ c)) ^ a0;
        a0 = a1;
        a1 = t;
      end
      rk[2*i+3] = a1;
      rk[2*i+4] = a0;
    end
  endtask

  function automatic logic [127:0] enc(input logic [127:0] pt);
    logic [127:0] x;
    x = pt;
    for (int i = 1; i <= 9; i++) x = lin(sbx(x ^ rk[i]));
    return x ^ rk[10];
  endfunction

  // External units: S box and key store are combinational; L unit finishes on its lat_n-th enabled cycle.
  int   lat_n;
  logic l_never;
  logic spur_fin;
  int   lcnt;
  int   cyc;

  assign s_out     = sbx(s_in);
  assign round_key = rk[int'(key_idx) + 1];
  assign l_finish  = spur_fin | (l_enable & ~l_never & (lcnt == lat_n - 1));
  assign l_output_word = spur_fin ? {4{32'hdeadbeef}} : lin(l_input_word);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (l_enable && !l_finish) lcnt <= lcnt + 1;
    else lcnt <= 0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] ct;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           total;
  int           bad;
  int           n_intervals;
  logic         len_prev;
  logic [127:0] last_ct;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done cycle=%0d ciphertext=%h required no done", cyc, ciphertext);
      end else begin
        e = sb.pop_front();
        if (ciphertext !== e.ct) begin
          bad++;
          $display("FAIL ciphertext got=%h required=%h", ciphertext, e.ct);
        end
        total++;
        if (cyc != e.due) begin
          bad++;
          $display("FAIL done_cycle got=%0d required=%0d", cyc, e.due);
        end
      end
    end
    if (l_enable && !len_prev) n_intervals++;
    len_prev = l_enable;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [127:0] ct, input int acc_cyc);
    exp_t e;
    e.ct  = ct;
    e.due = acc_cyc + 9 * (lat_n + 2) + 2;
    sb.push_back(e);
    last_ct = ct;
  endtask

  task automatic launch(input logic [127:0] pt, input logic [127:0] ct, input logic expect_done);
    start     = 1'b1;
    plaintext = pt;
    if (expect_done) push_exp(ct, cyc);
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain pending=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_round_lrun(input logic [3:0] idx, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (l_enable === 1'b1 && key_idx === idx) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_round_%0d got=timeout required=LRUN", idx);
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b1;
    tick();
    tick();
    @(negedge clk);
    total++;
    if ({busy, done, error, l_enable} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b required=0000", {busy, done, error, l_enable});
    end
    total++;
    if (ciphertext !== 128'h0) begin
      bad++;
      $display("FAIL reset_ciphertext got=%h required=0", ciphertext);
    end
    total++;
    if (key_idx !== 4'd0) begin
      bad++;
      $display("FAIL reset_key_idx got=%0d required=0", key_idx);
    end
    tick();
    rst   = 1'b0;
    start = 1'b0;
    tick();
  endtask

  task automatic test_gost;
    key_schedule(GOST_KEY);
    lat_n       = 17;
    n_intervals = 0;
    launch(GOST_PT, GOST_CT, 1'b1);
    drain(400, "gost");
    total++;
    if (n_intervals != 9) begin
      bad++;
      $display("FAIL gost_l_intervals got=%0d required=9", n_intervals);
    end
  endtask

  task automatic test_latency;
    int lats[3] = '{1, 5, 63};
    logic [127:0] pt;
    foreach (lats[i]) begin
      lat_n = lats[i];
      pt    = {$urandom, $urandom, $urandom, $urandom};
      launch(pt, enc(pt), 1'b1);
      drain(1000, "latency");
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] pa, pb;
    logic ok;
    lat_n = 3;
    pa = {$urandom, $urandom, $urandom, $urandom};
    pb = {$urandom, $urandom, $urandom, $urandom};
    start     = 1'b1;
    plaintext = pa;
    push_exp(enc(pa), cyc);
    tick();
    plaintext = pb;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL b2b_first_done got=timeout required=done");
    end
    push_exp(enc(pb), cyc);
    tick();
    start = 1'b0;
    drain(300, "b2b");
    tick();
  endtask

  task automatic test_busy_start;
    logic [127:0] pt;
    logic ok;
    lat_n = 4;
    pt = {$urandom, $urandom, $urandom, $urandom};
    launch(pt, enc(pt), 1'b1);
    wait_round_lrun(4'd3, ok);
    start     = 1'b1;
    plaintext = ~pt;
    tick();
    start = 1'b0;
    drain(300, "busy_start");
    repeat (60) tick();
  endtask

  task automatic test_timeout;
    logic [127:0] pt;
    l_never = 1'b1;
    launch(128'h0123456789abcdef0011223344556677, 128'h0, 1'b0);
    repeat (63) tick();
    @(negedge clk);
    total++;
    if ({l_enable, error} !== 2'b10) begin
      bad++;
      $display("FAIL timeout_last_lrun got=%b required=10", {l_enable, error});
    end
    tick();
    @(negedge clk);
    total++;
    if ({error, busy, l_enable} !== 3'b100) begin
      bad++;
      $display("FAIL timeout_err got=%b required=100", {error, busy, l_enable});
    end
    tick();
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if ({error, busy, l_enable} !== 3'b100) begin
      bad++;
      $display("FAIL timeout_start_ignored got=%b required=100", {error, busy, l_enable});
    end
    l_never = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL timeout_rst_clears got=%b required=0", error);
    end
    tick();
    lat_n = 2;
    pt = {$urandom, $urandom, $urandom, $urandom};
    launch(pt, enc(pt), 1'b1);
    drain(300, "after_timeout");
    tick();
  endtask

  task automatic test_reset_midop;
    logic [127:0] pt;
    logic ok;
    lat_n = 6;
    launch({$urandom, $urandom, $urandom, $urandom}, 128'h0, 1'b0);
    wait_round_lrun(4'd4, ok);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, l_enable} !== 2'b00) begin
      bad++;
      $display("FAIL midop_flags got=%b required=00", {busy, l_enable});
    end
    total++;
    if (ciphertext !== 128'h0) begin
      bad++;
      $display("FAIL midop_ciphertext got=%h required=0", ciphertext);
    end
    repeat (120) tick();
    pt = {$urandom, $urandom, $urandom, $urandom};
    launch(pt, enc(pt), 1'b1);
    drain(300, "after_midop");
    tick();
  endtask

  task automatic test_spurious;
    logic [127:0] pt;
    logic ok;
    lat_n    = 2;
    spur_fin = 1'b1;
    tick();
    tick();
    spur_fin = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || ciphertext !== last_ct) begin
      bad++;
      $display("FAIL spur_idle got busy=%b ct=%h required busy=0 ct=%h", busy, ciphertext, last_ct);
    end
    tick();
    pt = {$urandom, $urandom, $urandom, $urandom};
    launch(pt, enc(pt), 1'b1);
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (l_enable === 1'b1) ok = 1'b1;
    end
    for (int n = 0; n < 50 && ok; n++) begin
      @(negedge clk);
      if (l_enable === 1'b0) break;
    end
    spur_fin = 1'b1;
    @(posedge clk);
    #1;
    spur_fin = 1'b0;
    drain(300, "spurious");
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout got=stuck required=finish");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0; cyc = 0; lcnt = 0; n_intervals = 0;
    len_prev = 1'b0; last_ct = 128'h0;
    rst = 1'b1; start = 1'b0; plaintext = 128'h0;
    spur_fin = 1'b0; l_never = 1'b0; lat_n = 17;
    key_schedule(GOST_KEY);
    test_reset();
    test_gost();
    test_latency();
    test_back_to_back();
    test_busy_start();
    test_timeout();
    test_reset_midop();
    test_spurious();
    repeat (5) tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL final_scoreboard got=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
